// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state, error codes and frame constants
// for the instruction-memory byte-stream loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR_LO,
      HDR_HI,
      PAYLOAD,
      CKSUM,
      DONE,
      ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader_watchdog.sv
// imem_loader_watchdog: inter-byte stall counter with clear, enable
// and single-cycle expire when LIMIT idle cycles have elapsed.
module imem_loader_watchdog #(
   parameter int LIMIT = 65535
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = i_en & ~i_clr & (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: frame loader (LEN_LO, LEN_HI, 4N payload, XOR CSUM) into
// byte-wide imem. Define IMEM_LOADER_TIMEOUT_EN for the inter-byte watchdog.
import imem_loader_pkg::*;

module imem_loader #(
   parameter int ADDR_W         = 10,
   parameter int BASE_ADDR      = 0,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W-2:0] words_loaded
);

   localparam int MAX_WORDS = ((2 ** ADDR_W) - BASE_ADDR) / 4;
   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   state_t r_state;
   state_t w_next;

   logic              r_rx_ready;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_wdata;
   logic              r_hold;
   logic              r_done;
   logic              r_err;
   logic [1:0]        r_err_code;
   logic [ADDR_W-2:0] r_words;
   logic [7:0]        r_len_lo;
   logic [7:0]        r_xor;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_last;

   logic              w_acc;
   logic              w_active;
   logic              w_restart;
   logic              w_expire;
   logic [15:0]       w_len;
   logic [ADDR_W-1:0] w_last;
   logic [1:0]        w_code;

   assign w_acc     = rx_valid & r_rx_ready;
   assign w_active  = r_state inside {HDR_LO, HDR_HI, PAYLOAD, CKSUM};
   assign w_restart = start & (r_state inside {IDLE, DONE, ERROR});
   assign w_len     = {rx_data, r_len_lo};
   assign w_last    = ADDR_W'({w_len, 2'b00} - 18'd1);

`ifdef IMEM_LOADER_TIMEOUT_EN
   imem_loader_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clock    (clock),
      .reset    (reset),
      .i_clr    (w_acc | ~w_active),
      .i_en     (w_active),
      .o_expire (w_expire)
   );
`else
   // Never expires; the parameter only matters with the watchdog built in.
   assign w_expire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_code = ERR_NONE;
      unique case (r_state)
         IDLE, DONE, ERROR: begin
            if (start) w_next = HDR_LO;
         end
         HDR_LO: begin
            if (w_acc) w_next = HDR_HI;
         end
         HDR_HI: begin
            if (w_acc) begin
               if ({1'b0, w_len} > MAX_W) begin
                  w_next = ERROR;
                  w_code = ERR_LEN;
               end else if (w_len == 16'd0) begin
                  w_next = CKSUM;
               end else begin
                  w_next = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (w_acc && r_idx == r_last) w_next = CKSUM;
         end
         CKSUM: begin
            if (w_acc) begin
               if (rx_data == r_xor) begin
                  w_next = DONE;
               end else begin
                  w_next = ERROR;
                  w_code = ERR_CSUM;
               end
            end
         end
         default: w_next = IDLE;
      endcase
      if (w_expire) begin
         w_next = ERROR;
         w_code = ERR_TIMEOUT;
      end
   end

   // Status outputs follow the next state so they are registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rx_ready <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_hold     <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
         r_words    <= '0;
         r_len_lo   <= '0;
         r_xor      <= '0;
         r_idx      <= '0;
         r_last     <= '0;
      end else begin
         r_rx_ready <= w_next inside {HDR_LO, HDR_HI, PAYLOAD, CKSUM};
         r_done     <= (w_next == DONE);
         r_err      <= (w_next == ERROR);
         r_hold     <= (w_next != DONE);
         r_we       <= 1'b0;
         if (w_restart) begin
            r_xor      <= '0;
            r_idx      <= '0;
            r_words    <= '0;
            r_err_code <= ERR_NONE;
         end
         if (w_next == ERROR && r_state != ERROR) r_err_code <= w_code;
         if (w_acc) begin
            if (r_state != CKSUM) r_xor <= r_xor ^ rx_data;
            if (r_state == HDR_LO) r_len_lo <= rx_data;
            if (r_state == HDR_HI) r_last <= w_last;
            if (r_state == PAYLOAD) begin
               r_we    <= 1'b1;
               r_addr  <= BASE + r_idx;
               r_wdata <= rx_data;
               r_idx   <= r_idx + 1'b1;
               if (r_idx[1:0] == 2'b11) r_words <= r_words + 1'b1;
            end
         end
      end
   end

   assign rx_ready     = r_rx_ready;
   assign mem_we       = r_we;
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign cpu_hold     = r_hold;
   assign done         = r_done;
   assign err          = r_err;
   assign err_code     = r_err_code;
   assign words_loaded = r_words;

endmodule
